// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: PC-select encodings, fetch FSM states and
// the control-word field positions the control unit also decodes.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PS_HOLD   = 2'b00,
        PS_INC    = 2'b01,
        PS_BRANCH = 2'b10,
        PS_REG    = 2'b11
    } ps_sel_e;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'hD503201F;

    // Bit positions of IL and PS inside the control word.
    localparam int unsigned CW_IL_BIT = 0;
    localparam int unsigned CW_PS_LSB = 1;
    localparam int unsigned CW_PS_MSB = 2;

    // Word-granular 26-bit signed branch offset turned into a byte offset.
    function automatic logic [63:0] branch_offset(input logic [25:0] imm26);
        return {{36{imm26[25]}}, imm26, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and memory.
interface instruction_fetch_unit_if;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Combinational next-PC selection: hold, +4, relative branch, or register load.
module pc_next_logic
    import instruction_fetch_unit_pkg::*;
(
    input  logic [63:0] pc_i,
    input  logic [1:0]  ps_i,
    input  logic [63:0] k_i,
    input  logic [63:0] reg_a_i,
    output logic [63:0] pc_next_o
);

    logic [63:0] pc_inc;
    logic [63:0] pc_branch;
    logic [37:0] unused_k_hi;

    // Only the low 26 bits of k carry the branch offset.
    assign unused_k_hi = k_i[63:26];

    assign pc_inc    = pc_i + 64'd4;
    assign pc_branch = pc_i + branch_offset(k_i[25:0]);

    always_comb begin
        pc_next_o = pc_i;
        case (ps_sel_e'(ps_i))
            PS_HOLD:   pc_next_o = pc_i;
            PS_INC:    pc_next_o = pc_inc;
            PS_BRANCH: pc_next_o = pc_branch;
            PS_REG:    pc_next_o = reg_a_i;
            default:   pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns PC and IR, issues instruction-memory fetches and stalls
// the control unit while a fetch is outstanding.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                ps,
    input  logic                      il,
    input  logic [63:0]               k,
    input  logic [63:0]               reg_a,
    instruction_fetch_unit_if.master  imem,
    output logic [31:0]               instruction,
    output logic [63:0]               pc,
    output logic                      ir_valid,
    output logic                      stall,
    output logic                      fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_q;
    logic [63:0]      pc_q;
    logic [63:0]      pc_d;
    logic [63:0]      addr_q;
    logic             req_q;
    logic [31:0]      ir_q;
    logic             ir_valid_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;

    pc_next_logic u_pc_next (
        .pc_i      (pc_q),
        .ps_i      (ps),
        .k_i       (k),
        .reg_a_i   (reg_a),
        .pc_next_o (pc_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
            ir_q       <= NOP_INSTR;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ir_valid_q <= 1'b0;
            case (state_q)
                FETCH_IDLE: begin
                    // PC advances on the same edge that latches the fetch address,
                    // so a fetch always uses the pre-update PC.
                    pc_q <= pc_d;
                    if (il) begin
                        if (pc_q[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                        end else begin
                            addr_q  <= pc_q;
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= FETCH_WAIT;
                        end
                    end
                end
                FETCH_WAIT: begin
                    if (imem.imem_ready) begin
                        ir_q       <= imem.imem_rdata;
                        ir_valid_q <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= FETCH_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= FETCH_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= FETCH_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instruction    = ir_q;
    assign pc             = pc_q;
    assign ir_valid       = ir_valid_q;
    assign stall          = (state_q == FETCH_WAIT);
    assign fault          = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus
// randomized transactions against a behavioural PC/IR/fault model.
module tb_instruction_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam int unsigned TMO    = 6;
    localparam logic [31:0] NOP    = 32'hD503201F;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  ps;
    logic        il;
    logic [63:0] k;
    logic [63:0] reg_a;
    logic [31:0] instruction;
    logic [63:0] pc;
    logic        ir_valid;
    logic        stall;
    logic        fault;

    instruction_fetch_unit_if imem_if();

    instruction_fetch_unit #(
        .RESET_PC  (RST_PC),
        .TIMEOUT   (TMO),
        .NOP_INSTR (NOP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ps          (ps),
        .il          (il),
        .k           (k),
        .reg_a       (reg_a),
        .imem        (imem_if),
        .instruction (instruction),
        .pc          (pc),
        .ir_valid    (ir_valid),
        .stall       (stall),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    logic [63:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] ref_next_pc(input logic [63:0] cur, input logic [1:0] sel,
                                                input logic [63:0] kk, input logic [63:0] ra);
        logic [25:0] imm;
        longint      off;
        imm = kk[25:0];
        off = longint'($signed(imm)) * 4;
        case (sel)
            2'd0:    return cur;
            2'd1:    return cur + 64'd4;
            2'd2:    return cur + 64'(off);
            default: return ra;
        endcase
    endfunction

    task automatic apply_reset();
        ps = 2'd0; il = 1'b0; k = '0; reg_a = '0;
        imem_if.imem_ready = 1'b0; imem_if.imem_rdata = '0;
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        m_pc = RST_PC; m_ir = NOP; m_fault = 1'b0;
    endtask

    task automatic set_pc(input logic [63:0] v);
        ps = 2'd3; reg_a = v; il = 1'b0;
        cycle();
        ps = 2'd0;
        m_pc = v;
    endtask

    task automatic test_reset();
        ps = 2'd0; il = 1'b0; k = '0; reg_a = '0;
        imem_if.imem_ready = 1'b0; imem_if.imem_rdata = '0;
        reset = 1'b0;
        cycle();
        total++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); else passed++;
        total++; if (instruction !== NOP) $display("FAIL reset_ir: got %h expected %h", instruction, NOP); else passed++;
        total++; if (imem_if.imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_if.imem_req); else passed++;
        total++; if (imem_if.imem_addr !== 64'h0) $display("FAIL reset_addr: got %h expected 0", imem_if.imem_addr); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else passed++;
        total++; if (ir_valid !== 1'b0) $display("FAIL reset_irv: got %b expected 0", ir_valid); else passed++;
        reset = 1'b1;
        m_pc = RST_PC; m_ir = NOP; m_fault = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        set_pc(64'h40);
        il = 1'b1;
        cycle();
        il = 1'b0;
        total++; if (imem_if.imem_req !== 1'b1) $display("FAIL midrst_req_before: got %b expected 1", imem_if.imem_req); else passed++;
        #2;
        reset = 1'b0;
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 32'hDEADBEEF;
        #1;
        total++; if (imem_if.imem_req !== 1'b0) $display("FAIL midrst_req: got %b expected 0", imem_if.imem_req); else passed++;
        total++; if (pc !== RST_PC) $display("FAIL midrst_pc: got %h expected %h", pc, RST_PC); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL midrst_stall: got %b expected 0", stall); else passed++;
        cycle();
        total++; if (instruction !== NOP) $display("FAIL midrst_ir: got %h expected %h", instruction, NOP); else passed++;
        total++; if (ir_valid !== 1'b0) $display("FAIL midrst_irv: got %b expected 0", ir_valid); else passed++;
        imem_if.imem_ready = 1'b0;
        reset = 1'b1;
        m_pc = RST_PC; m_ir = NOP; m_fault = 1'b0;
    endtask

    task automatic test_sequential_fetch();
        int stall_cnt;
        il = 1'b1; ps = 2'd1;
        cycle();
        il = 1'b0; ps = 2'd0;
        total++; if (imem_if.imem_addr !== 64'h0) $display("FAIL seq_addr: got %h expected 0", imem_if.imem_addr); else passed++;
        total++; if (pc !== 64'h4) $display("FAIL seq_pc: got %h expected 4", pc); else passed++;
        total++; if (imem_if.imem_req !== 1'b1) $display("FAIL seq_req: got %b expected 1", imem_if.imem_req); else passed++;
        stall_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            if (stall === 1'b1) stall_cnt++;
            if (i == 3) begin
                imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 32'h8B020020;
            end
            cycle();
        end
        imem_if.imem_ready = 1'b0;
        if (stall === 1'b1) stall_cnt++;
        total++; if (stall_cnt != 3) $display("FAIL seq_stall_cycles: got %0d expected 3", stall_cnt); else passed++;
        total++; if (instruction !== 32'h8B020020) $display("FAIL seq_ir: got %h expected 8b020020", instruction); else passed++;
        total++; if (ir_valid !== 1'b1) $display("FAIL seq_irv_pulse: got %b expected 1", ir_valid); else passed++;
        total++; if (imem_if.imem_req !== 1'b0) $display("FAIL seq_req_drop: got %b expected 0", imem_if.imem_req); else passed++;
        cycle();
        total++; if (ir_valid !== 1'b0) $display("FAIL seq_irv_clear: got %b expected 0", ir_valid); else passed++;
        m_pc = 64'h4; m_ir = 32'h8B020020;
    endtask

    task automatic test_branch();
        set_pc(64'h100);
        ps = 2'd2; k = {$urandom, 6'($urandom), 26'h3FFFFFC};
        cycle();
        ps = 2'd0;
        total++; if (pc !== 64'hF0) $display("FAIL branch_back: got %h expected f0", pc); else passed++;
        set_pc(64'h100);
        ps = 2'd2; k = {$urandom, 6'($urandom), 26'h1FFFFFF};
        cycle();
        ps = 2'd0;
        total++; if (pc !== 64'h80000FC) $display("FAIL branch_fwd_max: got %h expected 80000fc", pc); else passed++;
        m_pc = 64'h80000FC;
    endtask

    task automatic test_wrap();
        set_pc(64'hFFFF_FFFF_FFFF_FFFC);
        ps = 2'd1;
        cycle();
        ps = 2'd0;
        total++; if (pc !== 64'h0) $display("FAIL wrap_inc: got %h expected 0", pc); else passed++;
        set_pc(64'hFFFF_FFFF_FFFF_FFF0);
        ps = 2'd2; k = 64'd8;
        cycle();
        ps = 2'd0;
        total++; if (pc !== 64'h10) $display("FAIL wrap_branch: got %h expected 10", pc); else passed++;
        m_pc = 64'h10;
    endtask

    task automatic test_wait_ignore();
        set_pc(64'h40);
        il = 1'b1; ps = 2'd0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            ps = 2'd3; reg_a = {$urandom, $urandom}; il = 1'b1;
            cycle();
        end
        ps = 2'd0; il = 1'b0;
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 32'hAA55_1234;
        cycle();
        imem_if.imem_ready = 1'b0;
        total++; if (pc !== 64'h40) $display("FAIL waitign_pc: got %h expected 40", pc); else passed++;
        total++; if (instruction !== 32'hAA55_1234) $display("FAIL waitign_ir: got %h expected aa551234", instruction); else passed++;
        cycle();
        total++; if (imem_if.imem_req !== 1'b0) $display("FAIL waitign_no_refetch: got %b expected 0", imem_if.imem_req); else passed++;
        m_ir = 32'hAA55_1234; m_pc = 64'h40;
    endtask

    task automatic test_timeout();
        int  cnt;
        logic irv_seen;
        set_pc(64'h80);
        total++; if (fault !== 1'b0) $display("FAIL tmo_fault_before: got %b expected 0", fault); else passed++;
        il = 1'b1;
        cycle();
        il = 1'b0;
        cnt = 0; irv_seen = 1'b0;
        while (imem_if.imem_req === 1'b1 && cnt < int'(TMO) + 5) begin
            cnt++;
            cycle();
            if (ir_valid === 1'b1) irv_seen = 1'b1;
        end
        total++; if (cnt != int'(TMO)) $display("FAIL tmo_req_cycles: got %0d expected %0d", cnt, TMO); else passed++;
        total++; if (fault !== 1'b1) $display("FAIL tmo_fault: got %b expected 1", fault); else passed++;
        total++; if (instruction !== m_ir || irv_seen) $display("FAIL tmo_ir_kept: got %h/irv %b expected %h/0", instruction, irv_seen, m_ir); else passed++;
        il = 1'b1;
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = 32'h1234_5678;
        cycle();
        il = 1'b0;
        total++; if (stall !== 1'b1 || ir_valid !== 1'b0) $display("FAIL idle_ready_ignored: got stall %b irv %b expected 1/0", stall, ir_valid); else passed++;
        cycle();
        imem_if.imem_ready = 1'b0;
        total++; if (instruction !== 32'h1234_5678 || ir_valid !== 1'b1) $display("FAIL tmo_refetch: got %h/%b expected 12345678/1", instruction, ir_valid); else passed++;
        total++; if (fault !== 1'b1) $display("FAIL tmo_fault_sticky: got %b expected 1", fault); else passed++;
        m_ir = 32'h1234_5678; m_fault = 1'b1;
    endtask

    task automatic test_misaligned();
        logic req_seen;
        apply_reset();
        set_pc(64'h202);
        total++; if (pc !== 64'h202) $display("FAIL br_load_pc: got %h expected 202", pc); else passed++;
        il = 1'b1;
        cycle();
        il = 1'b0;
        req_seen = imem_if.imem_req;
        total++; if (fault !== 1'b1) $display("FAIL misalign_fault: got %b expected 1", fault); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL misalign_stall: got %b expected 0", stall); else passed++;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (imem_if.imem_req !== 1'b0) req_seen = 1'b1;
        end
        total++; if (req_seen !== 1'b0) $display("FAIL misalign_no_req: got %b expected 0", req_seen); else passed++;
        total++; if (pc !== 64'h202) $display("FAIL misalign_pc: got %h expected 202", pc); else passed++;
        m_pc = 64'h202; m_fault = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0]  sel;
        logic        ld;
        logic        starts;
        logic [63:0] kk;
        logic [63:0] ra;
        logic [63:0] old_pc;
        logic [31:0] word;
        int unsigned lat;
        int unsigned stop_w;
        apply_reset();
        for (int t = 0; t < 60; t++) begin
            sel = 2'($urandom_range(0, 3));
            ld  = ($urandom_range(0, 2) != 0);
            kk  = {$urandom, $urandom};
            ra  = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
            word = $urandom;
            lat  = $urandom_range(1, TMO + 2);
            old_pc = m_pc;
            starts = ld && (old_pc[1:0] == 2'b00);
            if (ld && !starts) m_fault = 1'b1;
            m_pc = ref_next_pc(old_pc, sel, kk, ra);
            ps = sel; il = ld; k = kk; reg_a = ra;
            cycle();
            total++; if (pc !== m_pc) $display("FAIL rnd_pc t=%0d: got %h expected %h", t, pc, m_pc); else passed++;
            total++; if (imem_if.imem_req !== starts || stall !== starts || ir_valid !== 1'b0)
                $display("FAIL rnd_issue t=%0d: got req %b stall %b irv %b expected %b/%b/0", t, imem_if.imem_req, stall, ir_valid, starts, starts);
            else passed++;
            if (starts) begin
                total++; if (imem_if.imem_addr !== old_pc) $display("FAIL rnd_addr t=%0d: got %h expected %h", t, imem_if.imem_addr, old_pc); else passed++;
                stop_w = (lat <= TMO) ? lat : TMO;
                for (int unsigned w = 1; w <= stop_w; w++) begin
                    ps = 2'($urandom); il = 1'($urandom); reg_a = {$urandom, $urandom}; k = {$urandom, $urandom};
                    if (w == lat) begin
                        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = word;
                    end
                    total++; if (stall !== 1'b1 || imem_if.imem_req !== 1'b1)
                        $display("FAIL rnd_wait t=%0d w=%0d: got stall %b req %b expected 1/1", t, w, stall, imem_if.imem_req);
                    else passed++;
                    cycle();
                    imem_if.imem_ready = 1'b0;
                end
                if (lat <= TMO) m_ir = word; else m_fault = 1'b1;
                total++; if (ir_valid !== (lat <= TMO)) $display("FAIL rnd_irv t=%0d: got %b expected %b", t, ir_valid, (lat <= TMO)); else passed++;
                total++; if (stall !== 1'b0 || imem_if.imem_req !== 1'b0)
                    $display("FAIL rnd_end t=%0d: got stall %b req %b expected 0/0", t, stall, imem_if.imem_req);
                else passed++;
            end
            total++; if (instruction !== m_ir) $display("FAIL rnd_ir t=%0d: got %h expected %h", t, instruction, m_ir); else passed++;
            total++; if (fault !== m_fault) $display("FAIL rnd_fault t=%0d: got %b expected %b", t, fault, m_fault); else passed++;
            total++; if (pc !== m_pc) $display("FAIL rnd_pc_hold t=%0d: got %h expected %h", t, pc, m_pc); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fetch();
        test_sequential_fetch();
        test_branch();
        test_wrap();
        test_wait_ignore();
        test_timeout();
        test_misaligned();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
